xsim_dma_burst_engine: RTL and testbench
========================================

Name: xsim_dma_burst_engine

Overview:
Simulation-only DMA engine for the xsim top level. It turns burst read/write requests of configurable data width into per-32-bit-word DPI calls, read_simDma32 and write_simDma32. Read data returns through a parametrised response FIFO, so several beats can be outstanding. The block sits between the BSV memory-client wrapper and the C-side simulated memory, and supersedes the single-word, single-outstanding DMA shim.

Parameters:
DATAWIDTH, 64, beat width in bits; must be a multiple of 32 (W = DATAWIDTH/32 words per beat)
DEPTH, 4, read-response FIFO depth in beats; power of 2, >= 2
MAXBURST, 16, largest legal burst length in beats; <= 255

Ports:
CLK  input  1  clock
RST  input  1  reset, synchronous, active-high
req_valid  input  1  request offered
req_ready  output  1  high only in IDLE
req_write  input  1  1 = write burst, 0 = read burst
req_handle  input  32  memory handle passed to DPI
req_addr  input  32  byte address of beat 0
req_burst  input  8  beat count
wdata_valid  input  1  write beat offered
wdata_ready  output  1  high only in WRITE
wdata  input  DATAWIDTH  write beat
rdata_valid  output  1  FIFO not empty
rdata_ready  input  1  consumer pops head beat
rdata  output  DATAWIDTH  FIFO head beat
rdata_last  output  1  head beat is the final beat of its burst
wdone_valid  output  1  write burst complete; held until accepted
wdone_ready  input  1  consumer accepts wdone
err  output  1  one-cycle pulse on an illegal request
busy  output  1  state != IDLE or FIFO not empty

Behaviour:
- Reset (RST=1 at a CLK edge):
  - state -> IDLE; FIFO count, read pointer and write pointer -> 0.
  - err=0, wdone_valid=0; therefore rdata_valid=0 and busy=0.
  - No DPI calls occur in any cycle where RST=1.
  - Reset mid-burst aborts the burst; remaining beats are never issued and buffered read beats are discarded.
- FSM states: IDLE, READ, WRITE, WRESP.
- IDLE:
  - A request fires on req_valid & req_ready. The block latches handle, addr and beats_left = req_burst.
  - If req_burst == 0 or req_burst > MAXBURST: err pulses high for 1 cycle, the block stays in IDLE and makes no DPI call.
  - Otherwise it goes to READ or WRITE according to req_write.
- READ:
  - At each edge where FIFO count < DEPTH, evaluated before the same-edge pop (no bypass when full), the block issues W calls. Word i = read_simDma32(handle, addr + 4*i) fills bits [32i+31:32i].
  - That beat is pushed with last = (beats_left == 1); then addr += DATAWIDTH/8 and beats_left decrements.
  - After the last beat is pushed, the FSM returns to IDLE. The FIFO keeps draining, and a new request may be accepted while earlier read beats are still queued.
  - Latency: a request accepted at edge E0 issues its first read at E0+1, and rdata_valid is high after E0+1. With no backpressure, beat k is pushed at E0+1+k.
- FIFO:
  - A pop occurs on rdata_valid & rdata_ready.
  - A simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - rdata and rdata_last come from a registered head entry.
- WRITE:
  - On each wdata_valid & wdata_ready, the block calls write_simDma32(handle, addr + 4*i, wdata[32i+31:32i]) for i = 0..W-1 in ascending order, then advances addr and beats_left as in READ.
  - After the last beat it goes to WRESP.
- WRESP: wdone_valid=1 until wdone_ready. On that handshake it returns to IDLE, so the earliest next req_ready is the following cycle.
- Address arithmetic is 32-bit modulo; a wrap past 0xFFFFFFFC is legal and is not an error.
- wdata_valid outside WRITE is ignored and produces no DPI call. rdata_ready with an empty FIFO is ignored.

Optional Feature:
XSIM_DMA_WORD_ENABLE_EN:
- Defined: adds input wdata_wen[W-1:0]. In WRITE, word i is written only when wdata_wen[i]=1. addr still advances a full beat, and a beat with all enables 0 still counts toward beats_left.
- Undefined: no port is added and every word is written.

Test Plan:
- Read burst, DATAWIDTH=64, handle 3, addr 0x100, burst 4, rdata_ready=1 throughout, memory word at A = A:
  - Beats 0x00000104_00000100 … 0x0000011C_00000118, one per cycle from E0+1.
  - rdata_last set on beat 3 only; busy low afterwards.
- Backpressure, DEPTH=4, burst 8, rdata_ready=0 for 10 cycles:
  - Exactly 4 beats are buffered and no further read DPI calls occur.
  - After release, all 8 beats arrive in order with no loss or duplication.
- Write burst, burst 2, wdata 0x11111111_22222222 then 0x33333333_44444444 at addr 0x200:
  - Writes land at 0x200=0x22222222, 0x204=0x11111111, 0x208=0x44444444, 0x20C=0x33333333.
  - wdone_valid is held until wdone_ready.
- Illegal request, burst 0, then burst MAXBURST+1:
  - err pulses for one cycle each; no DPI activity; req_ready stays high.
- Reset asserted during beat 2 of an 8-beat read:
  - rdata_valid=0 and busy=0 after the reset edge; no further DPI reads.
  - A fresh request after reset completes normally.
- With XSIM_DMA_WORD_ENABLE_EN defined, wdata_wen=2'b10, addr 0x300:
  - Only 0x304 is written and 0x300 is unchanged.

Source files
------------

// File: rtl/xsim_dma_burst_engine.sv
// Simulation-only burst DMA: splits request beats into 32-bit simulated-memory calls.
// Optional per-word write enables are added when XSIM_DMA_WORD_ENABLE_EN is defined.

package xsim_dma_sim_pkg;
  // SystemVerilog stand-in for the C-side memory; unwritten words read back as their own address.
  logic [31:0] sim_mem [logic [63:0]];
  int unsigned rd_calls;
  int unsigned wr_calls;

  function automatic logic [31:0] read_simDma32(input logic [31:0] handle, input logic [31:0] addr);
    rd_calls++;
    return sim_mem.exists({handle, addr}) ? sim_mem[{handle, addr}] : addr;
  endfunction

  function automatic void write_simDma32(input logic [31:0] handle, input logic [31:0] addr,
                                         input logic [31:0] data);
    wr_calls++;
    sim_mem[{handle, addr}] = data;
  endfunction
endpackage

module xsim_dma_burst_engine #(
  parameter int DATAWIDTH = 64,
  parameter int DEPTH     = 4,
  parameter int MAXBURST  = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [31:0]            req_handle,
  input  logic [31:0]            req_addr,
  input  logic [7:0]             req_burst,
  input  logic                   wdata_valid,
  output logic                   wdata_ready,
`ifdef XSIM_DMA_WORD_ENABLE_EN
  input  logic [DATAWIDTH/32-1:0] wdata_wen,
`endif
  input  logic [DATAWIDTH-1:0]   wdata,
  output logic                   rdata_valid,
  input  logic                   rdata_ready,
  output logic [DATAWIDTH-1:0]   rdata,
  output logic                   rdata_last,
  output logic                   wdone_valid,
  input  logic                   wdone_ready,
  output logic                   err,
  output logic                   busy
);
  localparam int W  = DATAWIDTH / 32;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] BEAT_BYTES = 32'(DATAWIDTH / 8);

  typedef enum logic [1:0] {IDLE, READ, WRITE, WRESP} state_t;
  state_t state, state_nxt;

  logic [31:0]          handle_q;
  logic [31:0]          addr_q;
  logic [7:0]           beats_left;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 err_q;
  logic [DATAWIDTH-1:0] fifo_data [DEPTH];
  logic                 fifo_last [DEPTH];

  logic         req_fire, req_bad, rd_fire, wr_fire, pop, last_beat;
  logic [W-1:0] wen;

`ifdef XSIM_DMA_WORD_ENABLE_EN
  assign wen = wdata_wen;
`else
  assign wen = '1;
`endif

  function automatic logic [DATAWIDTH-1:0] read_beat(input logic [31:0] h, input logic [31:0] a);
    logic [DATAWIDTH-1:0] beat;
    beat = '0;
    for (int i = 0; i < W; i++)
      beat[32*i +: 32] = xsim_dma_sim_pkg::read_simDma32(h, a + 32'(4 * i));
    return beat;
  endfunction

  function automatic void write_beat(input logic [31:0] h, input logic [31:0] a,
                                     input logic [DATAWIDTH-1:0] d, input logic [W-1:0] en);
    for (int i = 0; i < W; i++)
      if (en[i]) xsim_dma_sim_pkg::write_simDma32(h, a + 32'(4 * i), d[32*i +: 32]);
  endfunction

  // Fullness is judged on the pre-pop count, so a full FIFO never bypasses.
  assign req_fire    = req_valid & req_ready;
  assign req_bad     = (req_burst == 8'd0) || (req_burst > 8'(MAXBURST));
  assign rd_fire     = (state == READ) && (count < CW'(DEPTH));
  assign wr_fire     = wdata_valid & wdata_ready;
  assign last_beat   = (beats_left == 8'd1);
  assign rdata_valid = (count != '0);
  assign pop         = rdata_valid & rdata_ready;
  assign rdata       = fifo_data[rd_ptr];
  assign rdata_last  = fifo_last[rd_ptr];
  assign err         = err_q;
  assign busy        = (state != IDLE) || rdata_valid;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    wdone_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !req_bad) state_nxt = req_write ? WRITE : READ;
      end
      READ:  if (rd_fire && last_beat) state_nxt = IDLE;
      WRITE: begin
        wdata_ready = 1'b1;
        if (wdata_valid && last_beat) state_nxt = WRESP;
      end
      WRESP: begin
        wdone_valid = 1'b1;
        if (wdone_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory calls live here so that no call can happen on a reset edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      err_q      <= 1'b0;
      handle_q   <= '0;
      addr_q     <= '0;
      beats_left <= '0;
    end else begin
      err_q <= req_fire && req_bad;
      if (req_fire) begin
        handle_q   <= req_handle;
        addr_q     <= req_addr;
        beats_left <= req_burst;
      end
      if (rd_fire) begin
        fifo_data[wr_ptr] <= read_beat(handle_q, addr_q);
        fifo_last[wr_ptr] <= last_beat;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (wr_fire) write_beat(handle_q, addr_q, wdata, wen);
      if (rd_fire || wr_fire) begin
        addr_q     <= addr_q + BEAT_BYTES;
        beats_left <= beats_left - 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(rd_fire) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_xsim_dma_burst_engine.sv
// Self-checking bench for xsim_dma_burst_engine: vector table, directed corner cases,
// and randomized requests checked against an address-level memory model.
module tb_xsim_dma_burst_engine;
  import xsim_dma_sim_pkg::*;

  localparam int DW   = 64;
  localparam int DEP  = 4;
  localparam int MAXB = 16;
  localparam int W    = DW / 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req_valid, req_ready, req_write;
  logic [31:0]   req_handle, req_addr;
  logic [7:0]    req_burst;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
`ifdef XSIM_DMA_WORD_ENABLE_EN
  logic [W-1:0]  wdata_wen;
`endif
  logic          rdata_valid, rdata_ready, rdata_last;
  logic [DW-1:0] rdata;
  logic          wdone_valid, wdone_ready, err, busy;

  xsim_dma_burst_engine #(.DATAWIDTH(DW), .DEPTH(DEP), .MAXBURST(MAXB)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_handle(req_handle), .req_addr(req_addr), .req_burst(req_burst),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
`ifdef XSIM_DMA_WORD_ENABLE_EN
    .wdata_wen(wdata_wen),
`endif
    .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata), .rdata_last(rdata_last),
    .wdone_valid(wdone_valid), .wdone_ready(wdone_ready), .err(err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_mem [logic [63:0]];

  typedef struct {
    logic        wr;
    logic [31:0] handle;
    logic [31:0] addr;
    logic [7:0]  burst;
    logic        exp_err;
  } vec_t;
  vec_t vecs [10];

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] h, input logic [31:0] a);
    return model_mem.exists({h, a}) ? model_mem[{h, a}] : a;
  endfunction

  function automatic logic [31:0] actual_word(input logic [31:0] h, input logic [31:0] a);
    return sim_mem.exists({h, a}) ? sim_mem[{h, a}] : a;
  endfunction

  // Beat k of a burst covers bytes base + k*DW/8 .. +DW/8-1, low word first.
  function automatic logic [DW-1:0] model_beat(input logic [31:0] h, input logic [31:0] base, input int k);
    logic [DW-1:0] b;
    for (int i = 0; i < W; i++) b[32*i +: 32] = model_word(h, base + 32'(k * (DW / 8) + 4 * i));
    return b;
  endfunction

  task automatic apply_stimulus(input logic wr, input logic [31:0] h, input logic [31:0] a,
                                input logic [7:0] n, output logic err_seen);
    int guard = 0;
    while (!req_ready && guard < 50) begin
      tick;
      guard++;
    end
    check_output("req_ready before request", req_ready, 1);
    req_valid = 1; req_write = wr; req_handle = h; req_addr = a; req_burst = n;
    tick;
    req_valid = 0;
    err_seen = err;
  endtask

  task automatic collect_beats(input logic [31:0] h, input logic [31:0] base, input int n, input bit rnd);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 8 * n + 40) begin
      rdata_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rdata_valid && rdata_ready) begin
        check_output("read beat data", rdata, model_beat(h, base, got));
        check_output("read beat last", rdata_last, (got == n - 1));
        got++;
      end
      tick;
      cyc++;
    end
    rdata_ready = 0;
    check_output("read beat count", got, n);
  endtask

  task automatic drive_write(input logic [31:0] h, input logic [31:0] a, input int n, output int unsigned nw);
    logic [DW-1:0] d;
    logic [W-1:0]  en;
    nw = 0;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) tick;
      for (int i = 0; i < W; i++) d[32*i +: 32] = $urandom;
      en = '1;
`ifdef XSIM_DMA_WORD_ENABLE_EN
      en = W'($urandom);
      wdata_wen = en;
`endif
      wdata_valid = 1;
      wdata = d;
      check_output("wdata_ready in write", wdata_ready, 1);
      tick;
      wdata_valid = 0;
      for (int i = 0; i < W; i++)
        if (en[i]) begin
          model_mem[{h, a + 32'(k * (DW / 8) + 4 * i)}] = d[32*i +: 32];
          nw++;
        end
    end
    repeat ($urandom_range(0, 3)) tick;
    check_output("wdone held", wdone_valid, 1);
    wdone_ready = 1;
    tick;
    wdone_ready = 0;
    check_output("wdone cleared", wdone_valid, 0);
    check_output("req_ready after wdone", req_ready, 1);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < W; i++) begin
        logic [31:0] wa;
        wa = a + 32'(k * (DW / 8) + 4 * i);
        check_output("memory after write", actual_word(h, wa), model_word(h, wa));
      end
  endtask

  task automatic do_request(input logic wr, input logic [31:0] h, input logic [31:0] a,
                            input logic [7:0] n, input logic exp_err);
    int unsigned rd0, wr0, nw;
    logic err_seen;
    rd0 = rd_calls;
    wr0 = wr_calls;
    apply_stimulus(wr, h, a, n, err_seen);
    check_output("err after request", err_seen, exp_err);
    if (exp_err) begin
      wdata_valid = 1;
      tick;
      wdata_valid = 0;
      check_output("err one cycle", err, 0);
      check_output("req_ready after err", req_ready, 1);
      check_output("no reads on err", rd_calls - rd0, 0);
      check_output("no writes on err", wr_calls - wr0, 0);
    end else if (wr) begin
      drive_write(h, a, int'(n), nw);
      check_output("write call count", wr_calls - wr0, nw);
      check_output("no reads in write", rd_calls - rd0, 0);
    end else begin
      collect_beats(h, a, int'(n), 1'b1);
      check_output("read call count", rd_calls - rd0, int'(n) * W);
      check_output("busy after read", busy, 0);
    end
  endtask

  initial begin
    int unsigned rd0, wr0;
    logic e;
    vecs[0] = '{1'b0, 32'd1, 32'h0000_1000, 8'd0,       1'b1};
    vecs[1] = '{1'b1, 32'd1, 32'h0000_1000, 8'(MAXB+1), 1'b1};
    vecs[2] = '{1'b0, 32'd2, 32'h0000_2000, 8'd1,       1'b0};
    vecs[3] = '{1'b1, 32'd2, 32'h0000_2100, 8'd3,       1'b0};
    vecs[4] = '{1'b0, 32'd2, 32'h0000_2100, 8'd3,       1'b0};
    vecs[5] = '{1'b0, 32'd0, 32'h0000_3000, 8'(MAXB),   1'b0};
    vecs[6] = '{1'b0, 32'd1, 32'hFFFF_FFF8, 8'd2,       1'b0};
    vecs[7] = '{1'b1, 32'd1, 32'hFFFF_FFF0, 8'd3,       1'b0};
    vecs[8] = '{1'b0, 32'd1, 32'hFFFF_FFF0, 8'd3,       1'b0};
    vecs[9] = '{1'b1, 32'd3, 32'h0000_5000, 8'd255,     1'b1};

    RST = 1; req_valid = 0; req_write = 0; req_handle = 0; req_addr = 0; req_burst = 0;
    wdata_valid = 0; wdata = '0; rdata_ready = 0; wdone_ready = 0;
`ifdef XSIM_DMA_WORD_ENABLE_EN
    wdata_wen = '1;
`endif
    tick;
    tick;
    check_output("reset req_ready", req_ready, 1);
    check_output("reset rdata_valid", rdata_valid, 0);
    check_output("reset busy", busy, 0);
    check_output("reset err", err, 0);
    check_output("reset wdone_valid", wdone_valid, 0);
    check_output("reset wdata_ready", wdata_ready, 0);
    RST = 0;
    tick;

    $display("[TB] read burst handle 3 addr 0x100 burst 4");
    rd0 = rd_calls;
    rdata_ready = 1;
    apply_stimulus(1'b0, 32'd3, 32'h100, 8'd4, e);
    check_output("read accept err", e, 0);
    check_output("read nothing yet", rdata_valid, 0);
    for (int k = 0; k < 4; k++) begin
      tick;
      check_output("read beat valid", rdata_valid, 1);
      check_output("read beat timed", rdata, model_beat(32'd3, 32'h100, k));
      check_output("read last timed", rdata_last, (k == 3));
      if (k == 0) check_output("read beat0 const", rdata, 64'h00000104_00000100);
      if (k == 3) check_output("read beat3 const", rdata, 64'h0000011C_00000118);
    end
    tick;
    rdata_ready = 0;
    check_output("read drained", rdata_valid, 0);
    check_output("read busy low", busy, 0);
    check_output("read call total", rd_calls - rd0, 4 * W);

    $display("[TB] backpressure burst 8");
    rd0 = rd_calls;
    apply_stimulus(1'b0, 32'd4, 32'h400, 8'd8, e);
    repeat (10) tick;
    check_output("bp reads stalled", rd_calls - rd0, DEP * W);
    check_output("bp head beat", rdata, model_beat(32'd4, 32'h400, 0));
    check_output("bp busy", busy, 1);
    collect_beats(32'd4, 32'h400, 8, 1'b0);
    check_output("bp reads total", rd_calls - rd0, 8 * W);
    check_output("bp busy low", busy, 0);

    $display("[TB] write burst 2 at 0x200");
    wr0 = wr_calls;
    apply_stimulus(1'b1, 32'd5, 32'h200, 8'd2, e);
    check_output("write wdata_ready", wdata_ready, 1);
    wdata_valid = 1; wdata = 64'h11111111_22222222;
    tick;
    wdata = 64'h33333333_44444444;
    tick;
    wdata_valid = 0;
    repeat (3) tick;
    check_output("write wdone held", wdone_valid, 1);
    check_output("write wdata_ready low", wdata_ready, 0);
    wdone_ready = 1;
    tick;
    wdone_ready = 0;
    check_output("write wdone done", wdone_valid, 0);
    check_output("write req_ready", req_ready, 1);
    check_output("write word 0x200", actual_word(32'd5, 32'h200), 32'h22222222);
    check_output("write word 0x204", actual_word(32'd5, 32'h204), 32'h11111111);
    check_output("write word 0x208", actual_word(32'd5, 32'h208), 32'h44444444);
    check_output("write word 0x20C", actual_word(32'd5, 32'h20C), 32'h33333333);
    check_output("write call total", wr_calls - wr0, 4);
    model_mem[{32'd5, 32'h200}] = 32'h22222222;
    model_mem[{32'd5, 32'h204}] = 32'h11111111;
    model_mem[{32'd5, 32'h208}] = 32'h44444444;
    model_mem[{32'd5, 32'h20C}] = 32'h33333333;

    $display("[TB] reset during 8-beat read");
    rd0 = rd_calls;
    rdata_ready = 1;
    apply_stimulus(1'b0, 32'd6, 32'h600, 8'd8, e);
    tick;
    tick;
    RST = 1;
    tick;
    check_output("rst rdata_valid", rdata_valid, 0);
    check_output("rst busy", busy, 0);
    check_output("rst req_ready", req_ready, 1);
    RST = 0;
    rdata_ready = 0;
    repeat (3) tick;
    check_output("rst reads aborted", rd_calls - rd0, 2 * W);
    do_request(1'b0, 32'd6, 32'h700, 8'd3, 1'b0);

`ifdef XSIM_DMA_WORD_ENABLE_EN
    $display("[TB] word enable 2'b10 at 0x300");
    wr0 = wr_calls;
    apply_stimulus(1'b1, 32'd7, 32'h300, 8'd1, e);
    wdata_valid = 1; wdata = 64'hAAAAAAAA_BBBBBBBB; wdata_wen = 2'b10;
    tick;
    wdata_valid = 0;
    wdone_ready = 1;
    tick;
    wdone_ready = 0;
    check_output("wen 0x300 untouched", sim_mem.exists({32'd7, 32'h300}), 0);
    check_output("wen 0x304 written", actual_word(32'd7, 32'h304), 32'hAAAAAAAA);
    check_output("wen call count", wr_calls - wr0, 1);
    model_mem[{32'd7, 32'h304}] = 32'hAAAAAAAA;
`endif

    $display("[TB] vector table");
    for (int v = 0; v < 10; v++)
      do_request(vecs[v].wr, vecs[v].handle, vecs[v].addr, vecs[v].burst, vecs[v].exp_err);

    $display("[TB] randomized requests");
    for (int r = 0; r < 30; r++) begin
      logic [7:0] n;
      n = 8'($urandom_range(0, MAXB + 2));
      do_request(1'($urandom_range(0, 1)), 32'($urandom_range(0, 3)),
                 32'h8000 + 32'(8 * $urandom_range(0, 31)), n, (n == 0) || (n > MAXB));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
